// File: rtl/ce_delay_pkg.sv
// Shared helpers for the multi-channel CE delay gate: width math, delay
// saturation and per-channel state encodings.
package ce_delay_pkg;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Bits needed to hold 0..max_delay inclusive.
  function automatic int unsigned delay_width(input int unsigned max_delay);
    return clog2(max_delay + 1);
  endfunction

  function automatic int unsigned sat_delay(input int unsigned value, input int unsigned max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/ce_delay_channels_if.sv
// Delay programming bus: write strobe and value in, current delay register out.
interface ce_delay_channels_if #(
  parameter int unsigned DW = 9
);
  logic          DELAY_WR;
  logic [DW-1:0] DELAY_IN;
  logic [DW-1:0] DELAY;

  modport master (output DELAY_WR, output DELAY_IN, input DELAY);
  modport slave  (input DELAY_WR, input DELAY_IN, output DELAY);
endinterface

// File: rtl/ce_delay_channel.sv
// One gated channel: counts CE=1 cycles down from the loaded delay, then
// passes CE until the next reset or restart.
module ce_delay_channel
  import ce_delay_pkg::*;
#(
  parameter int unsigned DW            = 9,
  parameter int unsigned DELAY_DEFAULT = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CE,
  input  logic          RESTART,
  input  logic [DW-1:0] DELAY,
  output logic          CE_OUT,
  output logic          READY
);

  localparam logic [0:0] ST_RESET = (DELAY_DEFAULT == 0) ? ST_PASS : ST_WAIT;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RESET;
      cnt_q   <= DW'(DELAY_DEFAULT);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Restart wins over counting; PASS is sticky and the counter never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (RESTART) begin
      cnt_d   = DELAY;
      state_d = (DELAY == '0) ? ST_PASS : ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (CE) begin
            if (cnt_q <= DW'(1)) begin
              cnt_d   = '0;
              state_d = ST_PASS;
            end else begin
              cnt_d = cnt_q - DW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign READY  = (state_q == ST_PASS);
  assign CE_OUT = CE & READY & ~RESTART & ~RESET;

endmodule

// File: rtl/ce_delay_channels.sv
// Multi-channel CE delay gate: shared programmable delay register feeding
// CHANNELS independently re-armable gates.
module ce_delay_channels
  import ce_delay_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned MAX_DELAY     = 256,
  parameter int unsigned DELAY_DEFAULT = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CE,
  input  logic [CHANNELS-1:0] RESTART,
  ce_delay_channels_if.slave  cfg,
  output logic [CHANNELS-1:0] CE_OUT,
  output logic [CHANNELS-1:0] READY,
  output logic                ALL_READY
);

  localparam int unsigned DW = delay_width(MAX_DELAY);

  logic [DW-1:0] delay_q;

  // Restarts in the same cycle as a write still see the old value.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      delay_q <= DW'(DELAY_DEFAULT);
    end else if (cfg.DELAY_WR) begin
      delay_q <= DW'(sat_delay(32'(cfg.DELAY_IN), MAX_DELAY));
    end
  end

  assign cfg.DELAY = delay_q;

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    ce_delay_channel #(
      .DW            (DW),
      .DELAY_DEFAULT (DELAY_DEFAULT)
    ) u_ch (
      .CLK     (CLK),
      .RESET   (RESET),
      .CE      (CE),
      .RESTART (RESTART[i]),
      .DELAY   (delay_q),
      .CE_OUT  (CE_OUT[i]),
      .READY   (READY[i])
    );
  end

  assign ALL_READY = &READY;

endmodule

// File: tb/tb_ce_delay_channels.sv
// Directed bench for ce_delay_channels: two instances (default 16 / max 256,
// and default 4 / max 8) driven from vector tables and a few hand sequences.
module tb_ce_delay_channels;
  import ce_delay_pkg::*;

  localparam int unsigned DW_A = delay_width(256);
  localparam int unsigned DW_B = delay_width(8);

  typedef struct {
    logic        sel;
    logic        ce;
    logic [3:0]  rs;
    logic        wr;
    logic [15:0] din;
    logic [3:0]  co;
    logic [3:0]  rdy;
    logic        all;
    logic [15:0] dly;
  } vec_t;

  logic       CLK;
  logic       rst_a, rst_b;
  logic       ce_a, ce_b;
  logic [3:0] rs_a, rs_b;
  logic [3:0] co_a, co_b, rdy_a, rdy_b;
  logic       all_a, all_b;

  int n_chk = 0;
  int n_err = 0;

  ce_delay_channels_if #(.DW(DW_A)) cfg_a ();
  ce_delay_channels_if #(.DW(DW_B)) cfg_b ();

  ce_delay_channels #(.CHANNELS(4), .MAX_DELAY(256), .DELAY_DEFAULT(16)) dut_a (
    .CLK(CLK), .RESET(rst_a), .CE(ce_a), .RESTART(rs_a), .cfg(cfg_a.slave),
    .CE_OUT(co_a), .READY(rdy_a), .ALL_READY(all_a)
  );

  ce_delay_channels #(.CHANNELS(4), .MAX_DELAY(8), .DELAY_DEFAULT(4)) dut_b (
    .CLK(CLK), .RESET(rst_b), .CE(ce_b), .RESTART(rs_b), .cfg(cfg_b.slave),
    .CE_OUT(co_b), .READY(rdy_b), .ALL_READY(all_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(input logic sel, input logic ce, input logic [3:0] rs,
                              input logic wr, input logic [15:0] din, input logic [3:0] co,
                              input logic [3:0] rdy, input logic all, input logic [15:0] dly);
    vec_t v;
    v.sel = sel; v.ce = ce; v.rs = rs; v.wr = wr; v.din = din;
    v.co = co; v.rdy = rdy; v.all = all; v.dly = dly;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
  task automatic apply(input vec_t v, input string name, input int idx);
    logic [3:0]  co, rdy;
    logic        all;
    logic [15:0] dly;
    ce_a = 1'b0; rs_a = '0; cfg_a.DELAY_WR = 1'b0; cfg_a.DELAY_IN = '0;
    ce_b = 1'b0; rs_b = '0; cfg_b.DELAY_WR = 1'b0; cfg_b.DELAY_IN = '0;
    if (!v.sel) begin
      ce_a = v.ce; rs_a = v.rs; cfg_a.DELAY_WR = v.wr; cfg_a.DELAY_IN = DW_A'(v.din);
    end else begin
      ce_b = v.ce; rs_b = v.rs; cfg_b.DELAY_WR = v.wr; cfg_b.DELAY_IN = DW_B'(v.din);
    end
    @(negedge CLK);
    if (!v.sel) begin
      co = co_a; rdy = rdy_a; all = all_a; dly = 16'(cfg_a.DELAY);
    end else begin
      co = co_b; rdy = rdy_b; all = all_b; dly = 16'(cfg_b.DELAY);
    end
    chk({name, ".ce_out"}, idx, 16'(co), 16'(v.co));
    chk({name, ".ready"}, idx, 16'(rdy), 16'(v.rdy));
    chk({name, ".all_ready"}, idx, 16'(all), 16'(v.all));
    chk({name, ".delay"}, idx, dly, v.dly);
    @(posedge CLK);
    #1;
  endtask

  // Continuous CE after reset on instance A: 16 blocked, 17th passes.
  task automatic run_default(input string name);
    for (int k = 1; k <= 17; k++) begin
      apply(mk(1'b0, 1'b1, 4'h0, 1'b0, 16'd0, (k == 17) ? 4'hF : 4'h0,
               (k == 17) ? 4'hF : 4'h0, (k == 17), 16'd16), name, k);
    end
  endtask

  vec_t tbl_a[24];
  vec_t tbl_b[6];

  initial begin
    // Instance A: per-channel restart, CE gap, write/restart collision, mid-count arm.
    tbl_a[0]  = mk(0, 0, 4'h0, 1, 16'd3,  4'h0, 4'hF, 1, 16'd16);
    tbl_a[1]  = mk(0, 1, 4'h4, 0, 16'd0,  4'hB, 4'hF, 1, 16'd3);
    tbl_a[2]  = mk(0, 0, 4'h0, 0, 16'd0,  4'h0, 4'hB, 0, 16'd3);
    tbl_a[3]  = mk(0, 1, 4'h0, 0, 16'd0,  4'hB, 4'hB, 0, 16'd3);
    tbl_a[4]  = mk(0, 1, 4'h0, 0, 16'd0,  4'hB, 4'hB, 0, 16'd3);
    tbl_a[5]  = mk(0, 1, 4'h0, 0, 16'd0,  4'hB, 4'hB, 0, 16'd3);
    tbl_a[6]  = mk(0, 1, 4'h0, 0, 16'd0,  4'hF, 4'hF, 1, 16'd3);
    tbl_a[7]  = mk(0, 0, 4'h0, 1, 16'd5,  4'h0, 4'hF, 1, 16'd3);
    tbl_a[8]  = mk(0, 1, 4'h1, 1, 16'd2,  4'hE, 4'hF, 1, 16'd5);
    tbl_a[9]  = mk(0, 1, 4'h0, 0, 16'd0,  4'hE, 4'hE, 0, 16'd2);
    tbl_a[10] = mk(0, 1, 4'h0, 0, 16'd0,  4'hE, 4'hE, 0, 16'd2);
    tbl_a[11] = mk(0, 1, 4'h0, 0, 16'd0,  4'hE, 4'hE, 0, 16'd2);
    tbl_a[12] = mk(0, 1, 4'h0, 0, 16'd0,  4'hE, 4'hE, 0, 16'd2);
    tbl_a[13] = mk(0, 1, 4'h0, 0, 16'd0,  4'hE, 4'hE, 0, 16'd2);
    tbl_a[14] = mk(0, 1, 4'h0, 0, 16'd0,  4'hF, 4'hF, 1, 16'd2);
    tbl_a[15] = mk(0, 1, 4'h1, 0, 16'd0,  4'hE, 4'hF, 1, 16'd2);
    tbl_a[16] = mk(0, 1, 4'h0, 0, 16'd0,  4'hE, 4'hE, 0, 16'd2);
    tbl_a[17] = mk(0, 1, 4'h0, 0, 16'd0,  4'hE, 4'hE, 0, 16'd2);
    tbl_a[18] = mk(0, 1, 4'h0, 0, 16'd0,  4'hF, 4'hF, 1, 16'd2);
    tbl_a[19] = mk(0, 0, 4'h0, 1, 16'd10, 4'h0, 4'hF, 1, 16'd2);
    tbl_a[20] = mk(0, 1, 4'h8, 0, 16'd0,  4'h7, 4'hF, 1, 16'd10);
    tbl_a[21] = mk(0, 1, 4'h0, 0, 16'd0,  4'h7, 4'h7, 0, 16'd10);
    tbl_a[22] = mk(0, 1, 4'h0, 0, 16'd0,  4'h7, 4'h7, 0, 16'd10);
    tbl_a[23] = mk(0, 1, 4'h0, 0, 16'd0,  4'h7, 4'h7, 0, 16'd10);
    // Instance B: saturation (13 -> 8) and zero delay after restart.
    tbl_b[0] = mk(1, 0, 4'h0, 1, 16'd13, 4'h0, 4'hF, 1, 16'd4);
    tbl_b[1] = mk(1, 1, 4'h2, 0, 16'd0,  4'hD, 4'hF, 1, 16'd8);
    tbl_b[2] = mk(1, 0, 4'h0, 1, 16'd0,  4'h0, 4'hD, 0, 16'd8);
    tbl_b[3] = mk(1, 1, 4'h2, 0, 16'd0,  4'hD, 4'hD, 0, 16'd0);
    tbl_b[4] = mk(1, 0, 4'h0, 0, 16'd0,  4'h0, 4'hF, 1, 16'd0);
    tbl_b[5] = mk(1, 1, 4'h0, 0, 16'd0,  4'hF, 4'hF, 1, 16'd0);

    rst_a = 1'b1; rst_b = 1'b1;
    ce_a = 1'b1; rs_a = '0; cfg_a.DELAY_WR = 1'b0; cfg_a.DELAY_IN = '0;
    ce_b = 1'b1; rs_b = '0; cfg_b.DELAY_WR = 1'b0; cfg_b.DELAY_IN = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_a.ce_out", 0, 16'(co_a), 16'h0);
    chk("rst_a.ready", 0, 16'(rdy_a), 16'h0);
    chk("rst_a.all_ready", 0, 16'(all_a), 16'h0);
    chk("rst_a.delay", 0, 16'(cfg_a.DELAY), 16'd16);
    chk("rst_b.ready", 0, 16'(rdy_b), 16'h0);
    chk("rst_b.delay", 0, 16'(cfg_b.DELAY), 16'd4);
    ce_a = 1'b0; ce_b = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;

    run_default("default");
    for (int i = 0; i < 24; i++) apply(tbl_a[i], "tbl_a", i);

    // Channel 3 now holds 7 remaining; async reset between edges with CE high.
    ce_a = 1'b1;
    #2;
    chk("midcount.ce_out", 0, 16'(co_a), 16'h7);
    rst_a = 1'b1;
    #1;
    chk("async.ce_out", 0, 16'(co_a), 16'h0);
    chk("async.ready", 0, 16'(rdy_a), 16'h0);
    chk("async.all_ready", 0, 16'(all_a), 16'h0);
    chk("async.delay", 0, 16'(cfg_a.DELAY), 16'd16);
    @(posedge CLK);
    #1;
    rst_a = 1'b0;
    run_default("rearm");

    // Sparse CE on B: pulses at cycles 1,4,7,10,13; only the fifth passes.
    for (int c = 1; c <= 15; c++) begin
      apply(mk(1'b1, (c % 3 == 1), 4'h0, 1'b0, 16'd0, (c == 13) ? 4'hF : 4'h0,
               (c >= 11) ? 4'hF : 4'h0, (c >= 11), 16'd4), "sparse", c);
    end
    for (int i = 0; i < 6; i++) apply(tbl_b[i], "tbl_b", i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
